// File: rtl/text_pixel_serializer.sv
// Text-mode pixel serialiser: one-deep character holding register feeding a
// column shifter, with a registered colour-index output stage and underrun flag.
module text_pixel_serializer #(
  parameter int unsigned FONT_WIDTH   = 8,
  parameter int unsigned CHAR_WIDTH   = 9,
  parameter bit          STRETCH_EN   = 1'b1,
  parameter logic [2:0]  STRETCH_MSBS = 3'b110
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [FONT_WIDTH-1:0] font_data,
  input  logic [7:0]            attribute_data,
  input  logic [2:0]            char_msbs,
  input  logic                  cursor_active,
  input  logic                  blink_state,
  input  logic                  extended_bg_colours,
  input  logic                  underrun_clear,
  output logic [3:0]            colour_index,
  output logic                  pixel_valid,
  output logic                  char_start,
  output logic                  underrun
);

  localparam int unsigned PAD_W = CHAR_WIDTH - FONT_WIDTH;
  localparam int unsigned COL_W = (CHAR_WIDTH > 1) ? $clog2(CHAR_WIDTH) : 1;
  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(CHAR_WIDTH - 1);
  localparam logic [CHAR_WIDTH-1:0] PAD_MASK = ~({CHAR_WIDTH{1'b1}} << PAD_W);

  // Holding register
  logic                  hold_full_q,   hold_full_d;
  logic [FONT_WIDTH-1:0] hold_font_q,   hold_font_d;
  logic [7:0]            hold_attr_q,   hold_attr_d;
  logic [2:0]            hold_msbs_q,   hold_msbs_d;
  logic                  hold_cursor_q, hold_cursor_d;

  // Shifter
  logic                  sh_valid_q,  sh_valid_d;
  logic [COL_W-1:0]      sh_col_q,    sh_col_d;
  logic [CHAR_WIDTH-1:0] sh_pix_q,    sh_pix_d;
  logic [7:0]            sh_attr_q,   sh_attr_d;
  logic                  sh_cursor_q, sh_cursor_d;

  // Output stage
  logic       underrun_q,    underrun_d;
  logic [3:0] colour_q,      colour_d;
  logic       pixel_valid_q, pixel_valid_d;
  logic       char_start_q,  char_start_d;

  logic                  boundary;
  logic                  transfer;
  logic                  accept;
  logic                  stretch;
  logic [CHAR_WIDTH-1:0] load_img;
  logic                  pix;
  logic                  fg_on;
  logic [3:0]            bg_colour;

  always_comb begin
    boundary   = enable & (~sh_valid_q | (sh_col_q == LAST_COL));
    transfer   = boundary & hold_full_q;
    load_ready = ~hold_full_q | transfer;
    accept     = load_valid & load_ready;
  end

  // Glyph sits left-justified in the cell; padding columns optionally repeat
  // the rightmost glyph column so box-drawing lines join across cells.
  always_comb begin
    stretch  = STRETCH_EN && (hold_msbs_q == STRETCH_MSBS);
    load_img = CHAR_WIDTH'(hold_font_q) << PAD_W;
    if (stretch && hold_font_q[0]) begin
      load_img = load_img | PAD_MASK;
    end
  end

  always_comb begin
    hold_full_d   = hold_full_q;
    hold_font_d   = hold_font_q;
    hold_attr_d   = hold_attr_q;
    hold_msbs_d   = hold_msbs_q;
    hold_cursor_d = hold_cursor_q;
    if (accept) begin
      hold_full_d   = 1'b1;
      hold_font_d   = font_data;
      hold_attr_d   = attribute_data;
      hold_msbs_d   = char_msbs;
      hold_cursor_d = cursor_active;
    end else if (transfer) begin
      hold_full_d   = 1'b0;
    end
  end

  always_comb begin
    sh_valid_d  = sh_valid_q;
    sh_col_d    = sh_col_q;
    sh_pix_d    = sh_pix_q;
    sh_attr_d   = sh_attr_q;
    sh_cursor_d = sh_cursor_q;
    if (boundary) begin
      if (hold_full_q) begin
        sh_valid_d  = 1'b1;
        sh_col_d    = '0;
        sh_pix_d    = load_img;
        sh_attr_d   = hold_attr_q;
        sh_cursor_d = hold_cursor_q;
      end else begin
        sh_valid_d  = 1'b0;
      end
    end else if (enable) begin
      sh_pix_d = sh_pix_q << 1;
      sh_col_d = sh_col_q + COL_W'(1);
    end
  end

  // Clear wins over a set landing on the same edge.
  always_comb begin
    underrun_d = underrun_q | (boundary & ~hold_full_q & sh_valid_q);
    if (underrun_clear) begin
      underrun_d = 1'b0;
    end
  end

  always_comb begin
    pix       = sh_pix_q[CHAR_WIDTH-1];
    fg_on     = sh_cursor_q
              | (~sh_attr_q[7] & pix)
              | (~extended_bg_colours & sh_attr_q[7] & blink_state & pix)
              | (extended_bg_colours & pix);
    bg_colour = extended_bg_colours ? sh_attr_q[7:4] : {1'b0, sh_attr_q[6:4]};
    pixel_valid_d = enable & sh_valid_q;
    char_start_d  = pixel_valid_d & (sh_col_q == '0);
    colour_d      = '0;
    if (pixel_valid_d) begin
      colour_d = fg_on ? sh_attr_q[3:0] : bg_colour;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_full_q   <= 1'b0;
      hold_font_q   <= '0;
      hold_attr_q   <= '0;
      hold_msbs_q   <= '0;
      hold_cursor_q <= 1'b0;
      sh_valid_q    <= 1'b0;
      sh_col_q      <= '0;
      sh_pix_q      <= '0;
      sh_attr_q     <= '0;
      sh_cursor_q   <= 1'b0;
      underrun_q    <= 1'b0;
      colour_q      <= '0;
      pixel_valid_q <= 1'b0;
      char_start_q  <= 1'b0;
    end else begin
      hold_full_q   <= hold_full_d;
      hold_font_q   <= hold_font_d;
      hold_attr_q   <= hold_attr_d;
      hold_msbs_q   <= hold_msbs_d;
      hold_cursor_q <= hold_cursor_d;
      sh_valid_q    <= sh_valid_d;
      sh_col_q      <= sh_col_d;
      sh_pix_q      <= sh_pix_d;
      sh_attr_q     <= sh_attr_d;
      sh_cursor_q   <= sh_cursor_d;
      underrun_q    <= underrun_d;
      colour_q      <= colour_d;
      pixel_valid_q <= pixel_valid_d;
      char_start_q  <= char_start_d;
    end
  end

  assign colour_index = colour_q;
  assign pixel_valid  = pixel_valid_q;
  assign char_start   = char_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_text_pixel_serializer.sv
// Directed bench for text_pixel_serializer: per-character vector table plus
// hand-written sequences for back-to-back, enable gaps and reset.
module tb_text_pixel_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       load_valid;
  logic [7:0] font_data;
  logic [7:0] attribute_data;
  logic [2:0] char_msbs;
  logic       cursor_active;
  logic       blink_state;
  logic       extended_bg_colours;
  logic       underrun_clear;

  logic       load_ready,  load_ready_ns;
  logic [3:0] colour,      colour_ns;
  logic       pv,          pv_ns;
  logic       cs,          cs_ns;
  logic       ur,          ur_ns;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  text_pixel_serializer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .load_valid(load_valid), .load_ready(load_ready),
    .font_data(font_data), .attribute_data(attribute_data),
    .char_msbs(char_msbs), .cursor_active(cursor_active),
    .blink_state(blink_state), .extended_bg_colours(extended_bg_colours),
    .underrun_clear(underrun_clear), .colour_index(colour),
    .pixel_valid(pv), .char_start(cs), .underrun(ur)
  );

  text_pixel_serializer #(.STRETCH_EN(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .enable(enable),
    .load_valid(load_valid), .load_ready(load_ready_ns),
    .font_data(font_data), .attribute_data(attribute_data),
    .char_msbs(char_msbs), .cursor_active(cursor_active),
    .blink_state(blink_state), .extended_bg_colours(extended_bg_colours),
    .underrun_clear(underrun_clear), .colour_index(colour_ns),
    .pixel_valid(pv_ns), .char_start(cs_ns), .underrun(ur_ns)
  );

  typedef struct {
    logic [7:0]  font;
    logic [7:0]  attr;
    logic [2:0]  msbs;
    logic        cursor;
    logic        blink;
    logic        ext;
    logic [35:0] exp;     // column 0 in the leftmost nibble
    logic [3:0]  pad_ns;  // column 8 on the non-stretching instance
  } row_t;

  localparam int NROWS = 11;
  row_t rows [NROWS];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [35:0] v, input int c);
    return v[35-4*c -: 4];
  endfunction

  initial begin
    logic [35:0] exp_a5;
    logic [35:0] e;
    exp_a5 = 36'hE1E11E1E1;

    rows[0]  = '{8'hA5, 8'h1E, 3'd0, 1'b0, 1'b0, 1'b0, 36'hE1E11E1E1, 4'h1};
    rows[1]  = '{8'h81, 8'h1E, 3'd6, 1'b0, 1'b0, 1'b0, 36'hE111111EE, 4'h1};
    rows[2]  = '{8'h81, 8'h1E, 3'd0, 1'b0, 1'b0, 1'b0, 36'hE111111E1, 4'h1};
    rows[3]  = '{8'hFF, 8'hF2, 3'd0, 1'b0, 1'b1, 1'b0, 36'h222222227, 4'h7};
    rows[4]  = '{8'hFF, 8'hF2, 3'd0, 1'b0, 1'b0, 1'b0, 36'h777777777, 4'h7};
    rows[5]  = '{8'hFF, 8'hF2, 3'd0, 1'b0, 1'b0, 1'b1, 36'h22222222F, 4'hF};
    rows[6]  = '{8'hFF, 8'hF2, 3'd0, 1'b1, 1'b0, 1'b0, 36'h222222222, 4'h2};
    rows[7]  = '{8'h00, 8'h1E, 3'd0, 1'b1, 1'b0, 1'b0, 36'hEEEEEEEEE, 4'hE};
    rows[8]  = '{8'hA5, 8'h9C, 3'd0, 1'b0, 1'b0, 1'b1, 36'hC9C99C9C9, 4'h9};
    rows[9]  = '{8'h80, 8'h1E, 3'd6, 1'b0, 1'b0, 1'b0, 36'hE11111111, 4'h1};
    rows[10] = '{8'hA5, 8'h9C, 3'd0, 1'b0, 1'b1, 1'b0, 36'hC1C11C1C1, 4'h1};

    // Reset held with a character offered
    reset = 1'b0; enable = 1'b1; load_valid = 1'b1;
    font_data = 8'hA5; attribute_data = 8'h1E; char_msbs = 3'd0;
    cursor_active = 1'b0; blink_state = 1'b0; extended_bg_colours = 1'b0;
    underrun_clear = 1'b0;
    repeat (3) step();
    chk("rst_colour", colour, 0);
    chk("rst_pv", pv, 0);
    chk("rst_cs", cs, 0);
    chk("rst_ur", ur, 0);
    chk("rst_ready", load_ready, 1);
    chk("rst_ready_ns", load_ready_ns, 1);
    load_valid = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_no_accept_pv", pv, 0);
    chk("rst_no_underrun", ur, 0);

    // Single characters from the vector table
    for (int r = 0; r < NROWS; r++) begin
      font_data = rows[r].font; attribute_data = rows[r].attr;
      char_msbs = rows[r].msbs; cursor_active = rows[r].cursor;
      blink_state = rows[r].blink; extended_bg_colours = rows[r].ext;
      e = rows[r].exp;
      load_valid = 1'b1; enable = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      chk($sformatf("row%0d_latency_pv", r), pv, 0);
      for (int c = 0; c < 9; c++) begin
        step();
        chk($sformatf("row%0d_col%0d", r, c), colour, nib(e, c));
        chk($sformatf("row%0d_col%0d_pv", r, c), pv, 1);
        chk($sformatf("row%0d_col%0d_cs", r, c), cs, (c == 0));
        chk($sformatf("row%0d_col%0d_ns", r, c), colour_ns,
            (c == 8) ? rows[r].pad_ns : nib(e, c));
        chk($sformatf("row%0d_col%0d_ns_pv", r, c), pv_ns, 1);
        chk($sformatf("row%0d_col%0d_ns_cs", r, c), cs_ns, (c == 0));
      end
      chk($sformatf("row%0d_underrun", r), ur, 1);
      chk($sformatf("row%0d_underrun_ns", r), ur_ns, 1);
      underrun_clear = 1'b1;
      step();
      underrun_clear = 1'b0;
      chk($sformatf("row%0d_cleared", r), ur, 0);
      chk($sformatf("row%0d_idle_pv", r), pv, 0);
      chk($sformatf("row%0d_idle_colour", r), colour, 0);
    end

    // Three characters back to back
    font_data = 8'hA5; attribute_data = 8'h1E; char_msbs = 3'd0;
    cursor_active = 1'b0; blink_state = 1'b0; extended_bg_colours = 1'b0;
    enable = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      load_valid = (k <= 10);
      if (k <= 10) chk($sformatf("b2b_ready_%0d", k), load_ready, (k == 0 || k == 1 || k == 10));
      step();
      chk($sformatf("b2b_pv_%0d", k), pv, (k >= 2 && k <= 28));
      if (k >= 2 && k <= 28) begin
        chk($sformatf("b2b_colour_%0d", k), colour, nib(exp_a5, (k - 2) % 9));
        chk($sformatf("b2b_cs_%0d", k), cs, ((k - 2) % 9 == 0));
      end
      chk($sformatf("b2b_ur_%0d", k), ur, (k >= 28));
    end
    underrun_clear = 1'b1;
    step();
    underrun_clear = 1'b0;

    // Enable gap mid-character; clear coincides with the underrun edge
    load_valid = 1'b1; enable = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("gap_pre_col%0d", c), colour, nib(exp_a5, c));
    end
    enable = 1'b0;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("gap_pv_%0d", g), pv, 0);
      chk($sformatf("gap_colour_%0d", g), colour, 0);
      chk($sformatf("gap_cs_%0d", g), cs, 0);
    end
    enable = 1'b1;
    for (int c = 3; c < 9; c++) begin
      if (c == 8) underrun_clear = 1'b1;
      step();
      chk($sformatf("gap_post_col%0d", c), colour, nib(exp_a5, c));
      chk($sformatf("gap_post_pv%0d", c), pv, 1);
      chk($sformatf("gap_post_cs%0d", c), cs, 0);
    end
    chk("clear_priority", ur, 0);
    underrun_clear = 1'b0;
    step();
    chk("clear_after_pv", pv, 0);
    chk("clear_after_ur", ur, 0);

    // Reset mid-character with a second character held
    load_valid = 1'b1; enable = 1'b1;
    step();
    step();
    load_valid = 1'b0;
    step();
    step();
    chk("midrst_pre_pv", pv, 1);
    reset = 1'b0;
    #1;
    chk("midrst_pv", pv, 0);
    chk("midrst_colour", colour, 0);
    chk("midrst_ready", load_ready, 1);
    step();
    reset = 1'b1;
    repeat (3) begin
      step();
      chk("midrst_dropped_pv", pv, 0);
    end
    chk("midrst_ur", ur, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
